// File: rtl/dot_sched_if.sv
// Command/result, operand-buffer and DSP-bank signals of the dot-product scheduler.
// The slave modport is the scheduler; master is the sequencer/SRAM/DSP side.
interface dot_sched_if #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 32
);
  localparam int OP_W = 18;
  localparam int PR_W = 37;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_W-1:0]        cmd_len;
  logic [ADDR_W-1:0]       cmd_base_a;
  logic [ADDR_W-1:0]       cmd_base_b;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr_a;
  logic [ADDR_W-1:0]       rd_addr_b;
  logic [LANES*8-1:0]      rd_data_a;
  logic [LANES*8-1:0]      rd_data_b;
  logic [LANES*OP_W-1:0]   dsp_a;
  logic [LANES*OP_W-1:0]   dsp_b;
  logic                    dsp_ce;
  logic [LANES*PR_W-1:0]   dsp_out;
  logic                    res_valid;
  logic                    res_ready;
  logic [ACC_W-1:0]        res_data;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_len, cmd_base_a, cmd_base_b, rd_data_a, rd_data_b, dsp_out, res_ready,
    output cmd_ready, rd_en, rd_addr_a, rd_addr_b, dsp_a, dsp_b, dsp_ce, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_len, cmd_base_a, cmd_base_b, rd_data_a, rd_data_b, dsp_out, res_ready,
    input  cmd_ready, rd_en, rd_addr_a, rd_addr_b, dsp_a, dsp_b, dsp_ce, res_valid, res_data, busy
  );
endinterface

// File: rtl/dot_sched.sv
// One job at a time: streams len chunks from the A/B buffers into the DSP bank and
// sums the low 16 bits of all lane products; result held on res_valid until res_ready.
module dot_sched #(
  parameter int LANES   = 16,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = 2,
  parameter int ACC_W   = 32
) (
  input logic        clk,
  input logic        rst_n,
  dot_sched_if.slave bus
);
  localparam int OP_W  = 18;
  localparam int PR_W  = 37;
  localparam int SUM_W = 16;
  localparam logic [DSP_LAT:0] LAST_ONLY = {1'b1, {DSP_LAT{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt;
  logic [ADDR_W-1:0]       base_a;
  logic [ADDR_W-1:0]       base_b;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        lane_sum;
  logic                    rd_vld;
  logic [DSP_LAT:0]        vld_sr;
  logic [LANES*OP_W-1:0]   op_a;
  logic [LANES*OP_W-1:0]   op_b;
  logic                    cmd_fire;
  logic                    last_rd;
  logic                    drain_done;

  assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
  assign last_rd    = (cnt == len_q - LEN_W'(1));
  // Only the final chunk is still in flight once everything behind it is empty.
  assign drain_done = (vld_sr == LAST_ONLY) && !rd_vld;

  assign bus.rd_addr_a = base_a + ADDR_W'(cnt);
  assign bus.rd_addr_b = base_b + ADDR_W'(cnt);
  assign bus.res_data  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.rd_en     = 1'b0;
    bus.dsp_ce    = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.busy      = 1'b0;
        bus.cmd_ready = rst_n;
        if (bus.cmd_valid)
          state_nxt = (bus.cmd_len == '0) ? RESULT : ISSUE;
      end
      ISSUE: begin
        bus.rd_en  = 1'b1;
        bus.dsp_ce = 1'b1;
        if (last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.dsp_ce = 1'b1;
        if (drain_done) state_nxt = RESULT;
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      cnt    <= '0;
      base_a <= '0;
      base_b <= '0;
      acc    <= '0;
    end else if (cmd_fire) begin
      len_q  <= bus.cmd_len;
      base_a <= bus.cmd_base_a;
      base_b <= bus.cmd_base_b;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      if (state == ISSUE)    cnt <= cnt + LEN_W'(1);
      if (vld_sr[DSP_LAT])   acc <= acc + lane_sum;
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (rd_vld) begin
      for (int z = 0; z < LANES; z++) begin
        op_a[z*OP_W +: OP_W] = {{(OP_W-8){1'b0}}, bus.rd_data_a[z*8 +: 8]};
        op_b[z*OP_W +: OP_W] = {{(OP_W-8){1'b0}}, bus.rd_data_b[z*8 +: 8]};
      end
    end
  end

  // Upper product bits [36:16] never contribute.
  always_comb begin
    lane_sum = '0;
    for (int z = 0; z < LANES; z++)
      lane_sum = lane_sum + ACC_W'(bus.dsp_out[z*PR_W +: SUM_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= 1'b0;
      vld_sr    <= '0;
      bus.dsp_a <= '0;
      bus.dsp_b <= '0;
    end else begin
      rd_vld    <= bus.rd_en;
      vld_sr    <= {vld_sr[DSP_LAT-1:0], rd_vld};
      bus.dsp_a <= op_a;
      bus.dsp_b <= op_b;
    end
  end
endmodule

// File: doc/dot_sched.md
# dot_sched

Command-driven scheduler for the 16-lane DSP multiply bank used by the NPU dot-product path. It accepts one dot-product job at a time: a vector length in 16-element chunks plus base addresses into the A/B operand buffers. It streams chunks from the operand buffers into the DSP bank and sums all lane products into a 32-bit result. The result is returned over a valid/ready handshake. It sits between the layer sequencer (command/result side) and the operand SRAMs plus DSP bank (datapath side).

## Interface
- LANES, 16, DSP lanes per chunk.
- ADDR_W, 8, operand buffer address width; one address holds one chunk.
- LEN_W, 8, chunk-count width.
- DSP_LAT, 2, cycles from operands presented on dsp_a/dsp_b to valid dsp_out.
- ACC_W, 32, accumulator/result width.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when cmd_valid && cmd_ready
- cmd_len  in  LEN_W  chunks to process; 0 is legal
- cmd_base_a / cmd_base_b  in  ADDR_W  first chunk address in A / B buffer
- rd_en  out  1  operand buffer read strobe, shared by both buffers
- rd_addr_a / rd_addr_b  out  ADDR_W  read addresses
- rd_data_a / rd_data_b  in  LANES*8  chunk data, valid the cycle after rd_en; lane z at [z*8 +: 8]
- dsp_a / dsp_b  out  LANES*18  DSP operands, lane z at [z*18 +: 18]
- dsp_ce  out  1  DSP bank clock enable
- dsp_out  in  LANES*37  DSP products, lane z at [z*37 +: 37]
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  ACC_W  dot-product result
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch len, base_a and base_b, and clear the accumulator.
  - If len=0, go to RESULT; otherwise go to ISSUE.
- ISSUE:
  - rd_en=1 every cycle for len cycles.
  - Chunk i uses rd_addr_a=base_a+i and rd_addr_b=base_b+i, both modulo 2^ADDR_W (wrap, no error).
  - After the last read, go to DRAIN.
- Operand load: the cycle after each rd_en, register every lane onto the DSP inputs: dsp_a lane = {10'd0, rd_data_a byte}, and likewise for dsp_b. In cycles with no returning data, drive dsp_a and dsp_b to 0.
- Valid tracking: a shift register of depth 1+DSP_LAT follows each chunk, so dsp_out is sampled exactly once per chunk.
- Accumulate: acc <= acc + Σ_{z=0..15} dsp_out[z][15:0], each term zero-extended to ACC_W, sum modulo 2^ACC_W. The full 16-lane sum is added in a single cycle; there is no per-lane last-writer behaviour.
- DRAIN: wait until the last chunk is accumulated, then go to RESULT.
- dsp_ce=1 in ISSUE and DRAIN; 0 in IDLE and RESULT.
- RESULT:
  - res_valid=1 and res_data=acc, both held stable until res_ready.
  - On handshake, go to IDLE.
  - cmd_ready stays 0 until IDLE.
- Jobs never overlap; a command arriving while busy waits (cmd_ready=0).

## Timing
- Reset values: cmd_ready=0 while rst_n is low, then 1 from the first cycle after deassertion. rd_en=0, rd_addr_a=rd_addr_b=0, dsp_a=dsp_b=0, dsp_ce=0, res_valid=0, res_data=0, busy=0, state=IDLE, acc=0.
- Command handshake at cycle 0 with len=N>0:
  - Chunk i is read in cycle 1+i.
  - Its operands are on dsp_a/dsp_b in cycle 3+i.
  - It is accumulated at the end of cycle 3+i+DSP_LAT.
  - res_valid rises in cycle N+3+DSP_LAT (7 for N=2, DSP_LAT=2).
- len=0: res_valid=1 with res_data=0 in cycle 1.
- Result handshake in cycle t: res_valid=0 and cmd_ready=1 in cycle t+1. Minimum job-to-job gap is 1 cycle.
- res_ready high in the same cycle res_valid rises completes the handshake in that cycle.
- Reset mid-job: everything returns to reset values asynchronously. In-flight DSP results are discarded, and nothing is accumulated after rst_n deasserts.
- dsp_out upper bits [36:16] are ignored.

## Test plan
- len=1, base 0, A=B=all 1 -> res_data=16; res_valid in cycle 6 (DSP_LAT=2).
- len=2, all bytes 255 -> res_data=32*65025=2080800; rd_addr_a 0,1 in cycles 1,2; dsp_ce high cycles 1-6.
- len=0 -> res_valid cycle 1, res_data=0, rd_en and dsp_ce never assert.
- base_a=255, base_b=10, len=2 -> rd_addr_a 255 then 0, rd_addr_b 10 then 11; lane products distinct (a=z, b=z+1) -> 2×Σz(z+1)=2×1360=2720.
- res_ready low 5 cycles with cmd_valid high -> res_data stable, cmd_ready=0; after handshake the next job is accepted 1 cycle later and its acc starts at 0.
- rst_n pulsed low during DRAIN -> all outputs at reset values; the next job of len=1 with all 1s returns exactly 16.
